bullet_engine: RTL

- Consumes the tank controller's fire and pose outputs (is_shooting, tank_dir, tank_X, tank_Y) and owns the full projectile lifecycle.
- Lifecycle: spawn at the muzzle, move one step per frame, detect screen walls and collision with the opposing tank, retire the bullet.
- Provides is_bullet for the colour mapper, the bullet position, hit status and an enemy hit counter for game logic.

---
 rtl/bullet_engine.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/bullet_engine.sv
`default_nettype none
// ============================================================================
//  Module   : bullet_engine
//  Purpose  : Single-projectile engine. Spawns a bullet at the shooter's
//             muzzle, advances it once per frame tick, retires it on a
//             screen wall or on contact with the enemy tank, and counts hits.
//  Ports    : Clk, Reset        - system clock, synchronous active-high reset
//             frame_clk         - asynchronous ~60 Hz frame level
//             DrawX, DrawY      - pixel currently being drawn
//             tank_X/Y, tank_dir, is_shooting - shooter pose and fire request
//             enemy_X/Y         - opposing tank top-left
//             is_bullet         - pixel lies inside the live bullet box
//             bullet_X/Y        - bullet top-left
//             hit_state         - 00 IDLE, 01 FLIGHT, 10 WALL, 11 HIT
//             enemy_hit         - one-Clk pulse on an enemy strike
//             hit_count         - saturating enemy hit counter
//  Options  : BULLET_COOLDOWN_EN - refire lockout of COOLDOWN_FRAMES ticks
//             after a bullet retires
//  Revision : 1.0 - initial release
// ============================================================================
module bullet_engine #(
`ifdef BULLET_COOLDOWN_EN
  parameter int COOLDOWN_FRAMES = 30,
`endif
  parameter int X_MAX        = 639,
  parameter int Y_MAX        = 479,
  parameter int TANK_W       = 32,
  parameter int TANK_H       = 32,
  parameter int BULLET_W     = 8,
  parameter int BULLET_H     = 8,
  parameter int BULLET_SPEED = 4
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  input  logic [9:0] tank_X,
  input  logic [9:0] tank_Y,
  input  logic [2:0] tank_dir,
  input  logic       is_shooting,
  input  logic [9:0] enemy_X,
  input  logic [9:0] enemy_Y,
  output logic       is_bullet,
  output logic [9:0] bullet_X,
  output logic [9:0] bullet_Y,
  output logic [1:0] hit_state,
  output logic       enemy_hit,
  output logic [7:0] hit_count
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_FLIGHT = 2'b01,
    S_WALL   = 2'b10,
    S_HIT    = 2'b11
  } state_t;

  // Muzzle offsets: centred across the tank, or flush with its far edge.
  localparam logic [9:0] C_OFF_CX = 10'((TANK_W - BULLET_W) / 2);
  localparam logic [9:0] C_OFF_FX = 10'(TANK_W - BULLET_W);
  localparam logic [9:0] C_OFF_CY = 10'((TANK_H - BULLET_H) / 2);
  localparam logic [9:0] C_OFF_FY = 10'(TANK_H - BULLET_H);

  localparam logic signed [10:0] C_STEP   = 11'(BULLET_SPEED);
  localparam logic signed [11:0] C_BW_M1  = 12'(BULLET_W - 1);
  localparam logic signed [11:0] C_BH_M1  = 12'(BULLET_H - 1);
  localparam logic signed [11:0] C_TW_M1  = 12'(TANK_W - 1);
  localparam logic signed [11:0] C_TH_M1  = 12'(TANK_H - 1);
  localparam logic signed [11:0] C_XMAX   = 12'(X_MAX);
  localparam logic signed [11:0] C_YMAX   = 12'(Y_MAX);
  localparam logic [10:0]        C_BW_U   = 11'(BULLET_W - 1);
  localparam logic [10:0]        C_BH_U   = 11'(BULLET_H - 1);

  state_t     state_q;
  logic [2:0] dir_q;
  logic [9:0] bx_q, by_q;
  logic       frame_d1_q, frame_d2_q, tick_q;
  logic       fire_pending_q;
  logic       enemy_hit_q;
  logic [7:0] hit_count_q;

  logic signed [10:0] nx_d, ny_d;
  logic signed [11:0] nx_e, ny_e, ex_lo, ey_lo;
  logic               hit_d, wall_d;
  logic [9:0]         spawn_x_d, spawn_y_d;
  logic               dir_ok;
  logic               cooldown_busy;

`ifdef BULLET_COOLDOWN_EN
  localparam int CD_W = $clog2(COOLDOWN_FRAMES + 1);
  localparam logic [CD_W-1:0] C_CD_LOAD = CD_W'(COOLDOWN_FRAMES);
  logic [CD_W-1:0] cd_q;
  assign cooldown_busy = (cd_q != '0);
`else
  assign cooldown_busy = 1'b0;
`endif

  // Candidate position one step along the latched direction.
  always_comb begin
    nx_d = $signed({1'b0, bx_q});
    ny_d = $signed({1'b0, by_q});
    case (dir_q)
      3'd1:    ny_d = ny_d - C_STEP;
      3'd2:    nx_d = nx_d + C_STEP;
      3'd3:    nx_d = nx_d - C_STEP;
      3'd4:    ny_d = ny_d + C_STEP;
      default: ;
    endcase
  end

  // Box tests in 12 bits so enemy far edges near 1023 cannot wrap.
  assign nx_e  = {nx_d[10], nx_d};
  assign ny_e  = {ny_d[10], ny_d};
  assign ex_lo = $signed({2'b00, enemy_X});
  assign ey_lo = $signed({2'b00, enemy_Y});

  assign hit_d = (nx_e <= ex_lo + C_TW_M1) && (nx_e + C_BW_M1 >= ex_lo) &&
                 (ny_e <= ey_lo + C_TH_M1) && (ny_e + C_BH_M1 >= ey_lo);

  assign wall_d = (nx_d < 0) || (ny_d < 0) ||
                  (nx_e + C_BW_M1 > C_XMAX) || (ny_e + C_BH_M1 > C_YMAX);

  assign dir_ok = (tank_dir >= 3'd1) && (tank_dir <= 3'd4);

  always_comb begin
    spawn_x_d = tank_X;
    spawn_y_d = tank_Y;
    case (tank_dir)
      3'd1: spawn_x_d = tank_X + C_OFF_CX;
      3'd2: begin
        spawn_x_d = tank_X + C_OFF_FX;
        spawn_y_d = tank_Y + C_OFF_CY;
      end
      3'd3: spawn_y_d = tank_Y + C_OFF_CY;
      3'd4: begin
        spawn_x_d = tank_X + C_OFF_CX;
        spawn_y_d = tank_Y + C_OFF_FY;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q        <= S_IDLE;
      dir_q          <= 3'd0;
      bx_q           <= 10'd0;
      by_q           <= 10'd0;
      frame_d1_q     <= 1'b0;
      frame_d2_q     <= 1'b0;
      tick_q         <= 1'b0;
      fire_pending_q <= 1'b0;
      enemy_hit_q    <= 1'b0;
      hit_count_q    <= 8'd0;
`ifdef BULLET_COOLDOWN_EN
      cd_q           <= '0;
`endif
    end else begin
      frame_d1_q  <= frame_clk;
      frame_d2_q  <= frame_d1_q;
      tick_q      <= frame_d1_q & ~frame_d2_q;
      enemy_hit_q <= 1'b0;

      // The tick consumes the request, so a clear beats a same-cycle set.
      if (tick_q)
        fire_pending_q <= 1'b0;
      else if (is_shooting && (state_q == S_IDLE))
        fire_pending_q <= 1'b1;

      if (tick_q) begin
        case (state_q)
          S_IDLE: begin
`ifdef BULLET_COOLDOWN_EN
            if (cd_q != '0)
              cd_q <= cd_q - 1'b1;
`endif
            if (fire_pending_q && dir_ok && !cooldown_busy) begin
              state_q <= S_FLIGHT;
              dir_q   <= tank_dir;
              bx_q    <= spawn_x_d;
              by_q    <= spawn_y_d;
            end
          end
          S_FLIGHT: begin
            if (hit_d) begin
              state_q     <= S_HIT;
              enemy_hit_q <= 1'b1;
              if (hit_count_q != 8'hFF)
                hit_count_q <= hit_count_q + 8'd1;
            end else if (wall_d) begin
              state_q <= S_WALL;
            end else begin
              bx_q <= nx_d[9:0];
              by_q <= ny_d[9:0];
            end
          end
          S_WALL, S_HIT: begin
            state_q <= S_IDLE;
`ifdef BULLET_COOLDOWN_EN
            cd_q    <= C_CD_LOAD;
`endif
          end
        endcase
      end
    end
  end

  assign is_bullet = (state_q == S_FLIGHT) &&
                     ({1'b0, DrawX} >= {1'b0, bx_q}) &&
                     ({1'b0, DrawX} <= {1'b0, bx_q} + C_BW_U) &&
                     ({1'b0, DrawY} >= {1'b0, by_q}) &&
                     ({1'b0, DrawY} <= {1'b0, by_q} + C_BH_U);

  assign bullet_X  = bx_q;
  assign bullet_Y  = by_q;
  assign hit_state = state_q;
  assign enemy_hit = enemy_hit_q;
  assign hit_count = hit_count_q;

endmodule
`default_nettype wire
